// File: rtl/rd_req_arbiter_pkg.sv
// Shared definitions for the read-request arbiter slice.
package rd_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic CMD_READ = 1'b1;

endpackage

// File: rtl/rd_req_arbiter_tag_fifo.sv
// Origin-tag FIFO: remembers which source issued each outstanding read.
module rd_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic not_empty,
  output logic full
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign head      = not_empty ? mem_q[rd_ptr_q] : 1'b0;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && not_empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// Two-source read-request arbiter with per-source pending slots and an
// origin-tag FIFO for routing read completions back to their source.
module rd_req_arbiter
  import rd_req_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [1:0]        s_wren,
  input  logic [AWIDTH-1:0] s0_addr,
  input  logic [AWIDTH-1:0] s1_addr,
  output logic [1:0]        s_busy,
  output logic [1:0]        drop_err,
  output logic              m_req,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_cmd,
  input  logic              m_ack,
  input  logic              m_rvalid,
  output logic              rsp_src,
  output logic              rsp_pending,
  output logic              rsp_err
);

  arb_state_e             state_q, state_d;
  logic [1:0]             slot_vld_q, slot_vld_d;
  logic [1:0][AWIDTH-1:0] slot_addr_q, slot_addr_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [1:0]             drop_err_q, drop_err_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [1:0]             clr;
  logic [1:0][AWIDTH-1:0] src_addr;
  logic                   tag_push, tag_full, tag_not_empty, tag_head;
  logic                   winner;

  assign src_addr = {s1_addr, s0_addr};

  // Slot bookkeeping, FSM next state and grant selection.
  always_comb begin
    state_d      = state_q;
    slot_vld_d   = slot_vld_q;
    slot_addr_d  = slot_addr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_err_d   = '0;
    rsp_err_d    = m_rvalid && !tag_not_empty;
    tag_push     = 1'b0;
    clr          = '0;
    winner       = (slot_vld_q == 2'b11) ? ~last_grant_q : slot_vld_q[1];

    case (state_q)
      IDLE: begin
        if ((slot_vld_q != '0) && !tag_full) begin
          state_d      = ISSUE;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      ISSUE: begin
        if (m_ack) begin
          state_d       = RELEASE;
          tag_push      = 1'b1;
          clr[grant_q]  = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A strobe arriving on the clearing edge refills the slot instead of dropping.
    for (int unsigned i = 0; i < 2; i++) begin
      if (clr[i]) slot_vld_d[i] = 1'b0;
      if (s_wren[i]) begin
        if (!slot_vld_q[i] || clr[i]) begin
          slot_vld_d[i]  = 1'b1;
          slot_addr_d[i] = src_addr[i];
        end else begin
          drop_err_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      slot_vld_q   <= '0;
      slot_addr_q  <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      drop_err_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_vld_q   <= slot_vld_d;
      slot_addr_q  <= slot_addr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_err_q   <= drop_err_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  rd_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push     (tag_push),
    .push_data(grant_q),
    .pop      (m_rvalid),
    .head     (tag_head),
    .not_empty(tag_not_empty),
    .full     (tag_full)
  );

  assign m_req       = (state_q == ISSUE);
  assign m_cmd       = (state_q == ISSUE) ? CMD_READ : 1'b0;
  assign m_addr      = (state_q == ISSUE) ? slot_addr_q[grant_q] : '0;
  assign s_busy      = slot_vld_q;
  assign drop_err    = drop_err_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_src     = tag_head;
  assign rsp_pending = tag_not_empty;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed self-checking bench for rd_req_arbiter.
module tb_rd_req_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  s_wren;
  logic [31:0] s0_addr, s1_addr;
  logic [1:0]  s_busy, drop_err;
  logic        m_req, m_cmd, m_ack, m_rvalid;
  logic [31:0] m_addr;
  logic        rsp_src, rsp_pending, rsp_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 aclk = ~aclk;

  rd_req_arbiter #(.AWIDTH(32), .TAG_DEPTH(4)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_wren     (s_wren),
    .s0_addr    (s0_addr),
    .s1_addr    (s1_addr),
    .s_busy     (s_busy),
    .drop_err   (drop_err),
    .m_req      (m_req),
    .m_addr     (m_addr),
    .m_cmd      (m_cmd),
    .m_ack      (m_ack),
    .m_rvalid   (m_rvalid),
    .rsp_src    (rsp_src),
    .rsp_pending(rsp_pending),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_wren   = '0;
    m_ack    = 1'b0;
    m_rvalid = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Load one request from source 0, wait for it to issue, then ack it.
  task automatic issue_one(input logic [31:0] a, input string tag);
    int unsigned n;
    s_wren  = 2'b01;
    s0_addr = a;
    tick();
    s_wren = '0;
    n = 0;
    while (!m_req && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, m_req}, 32'd1);
    chk({tag, "_addr"}, m_addr, a);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    s0_addr = '0;
    s1_addr = '0;
    do_reset();

    // Reset state.
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_cmd", {31'd0, m_cmd}, 32'd0);
    chk("rst_s_busy", {30'd0, s_busy}, 32'd0);
    chk("rst_pending", {31'd0, rsp_pending}, 32'd0);
    chk("rst_drop", {30'd0, drop_err}, 32'd0);

    // Single request from source 0.
    s_wren  = 2'b01;
    s0_addr = 32'h0000_0010;
    tick();
    s_wren = '0;
    chk("single_busy", {30'd0, s_busy}, 32'd1);
    chk("single_req_e0", {31'd0, m_req}, 32'd0);
    tick();
    chk("single_req", {31'd0, m_req}, 32'd1);
    chk("single_addr", m_addr, 32'h10);
    chk("single_cmd", {31'd0, m_cmd}, 32'd1);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    chk("single_rel_req", {31'd0, m_req}, 32'd0);
    chk("single_rel_addr", m_addr, 32'd0);
    chk("single_busy_clr", {30'd0, s_busy}, 32'd0);
    chk("single_pending", {31'd0, rsp_pending}, 32'd1);
    chk("single_src", {31'd0, rsp_src}, 32'd0);
    tick();
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("single_popped", {31'd0, rsp_pending}, 32'd0);
    tick();
    chk("single_no_err", {31'd0, rsp_err}, 32'd0);

    // Tie: both sources at once, m_ack held high throughout.
    do_reset();
    s_wren  = 2'b11;
    s0_addr = 32'h0000_0010;
    s1_addr = 32'h8000_0020;
    m_ack   = 1'b1;
    tick();
    s_wren = '0;
    chk("tie_busy", {30'd0, s_busy}, 32'd3);
    tick();
    chk("tie_g0_req", {31'd0, m_req}, 32'd1);
    chk("tie_g0_addr", m_addr, 32'h10);
    tick();
    chk("tie_rel0_req", {31'd0, m_req}, 32'd0);
    chk("tie_rel0_busy", {30'd0, s_busy}, 32'd2);
    tick();
    chk("tie_idle_req", {31'd0, m_req}, 32'd0);
    tick();
    chk("tie_g1_req", {31'd0, m_req}, 32'd1);
    chk("tie_g1_addr", m_addr, 32'h8000_0020);
    tick();
    tick();
    tick();
    m_ack = 1'b0;
    chk("tie_busy_clr", {30'd0, s_busy}, 32'd0);
    chk("tie_pending", {31'd0, rsp_pending}, 32'd1);
    chk("tie_src0", {31'd0, rsp_src}, 32'd0);
    m_rvalid = 1'b1;
    tick();
    chk("tie_src1", {31'd0, rsp_src}, 32'd1);
    chk("tie_pending1", {31'd0, rsp_pending}, 32'd1);
    tick();
    m_rvalid = 1'b0;
    chk("tie_drained", {31'd0, rsp_pending}, 32'd0);
    chk("tie_no_err", {31'd0, rsp_err}, 32'd0);

    // Drop: second strobe while slot 0 still pending.
    do_reset();
    s_wren  = 2'b01;
    s0_addr = 32'h0000_0100;
    tick();
    s_wren = '0;
    chk("drop_none_yet", {30'd0, drop_err}, 32'd0);
    tick();
    s_wren  = 2'b01;
    s0_addr = 32'h0000_0200;
    tick();
    s_wren = '0;
    chk("drop_pulse", {30'd0, drop_err}, 32'd1);
    tick();
    chk("drop_one_pulse", {30'd0, drop_err}, 32'd0);
    chk("drop_req", {31'd0, m_req}, 32'd1);
    chk("drop_addr_kept", m_addr, 32'h100);

    // Full: four issued reads fill the tag FIFO, fifth waits for a completion.
    do_reset();
    issue_one(32'h0000_1000, "full1");
    issue_one(32'h0000_1004, "full2");
    issue_one(32'h0000_1008, "full3");
    issue_one(32'h0000_100C, "full4");
    s_wren  = 2'b01;
    s0_addr = 32'h0000_0055;
    tick();
    s_wren = '0;
    tick();
    tick();
    tick();
    tick();
    chk("full_wait_req", {31'd0, m_req}, 32'd0);
    chk("full_wait_busy", {30'd0, s_busy}, 32'd1);
    chk("full_pending", {31'd0, rsp_pending}, 32'd1);
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("full_after_pop_req", {31'd0, m_req}, 32'd0);
    tick();
    chk("full_5th_req", {31'd0, m_req}, 32'd1);
    chk("full_5th_addr", m_addr, 32'h55);

    // Errors: completion with empty FIFO, then reset in the middle of ISSUE.
    do_reset();
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("err_pulse", {31'd0, rsp_err}, 32'd1);
    tick();
    chk("err_one_pulse", {31'd0, rsp_err}, 32'd0);
    s_wren  = 2'b01;
    s0_addr = 32'h0000_0070;
    tick();
    s_wren = '0;
    tick();
    chk("rst_mid_req_before", {31'd0, m_req}, 32'd1);
    m_ack = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, m_req}, 32'd0);
    chk("rst_mid_addr", m_addr, 32'd0);
    chk("rst_mid_pending", {31'd0, rsp_pending}, 32'd0);
    chk("rst_mid_busy", {30'd0, s_busy}, 32'd0);
    tick();
    m_ack   = 1'b0;
    aresetn = 1'b1;
    tick();
    chk("rst_mid_no_push", {31'd0, rsp_pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
